// File: rtl/mux_nx1_rr_pkg.sv
// Shared definitions for the N:1 registered mux: mode encodings and select-width helper.
package mux_pkg;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   // Bits needed to index n items; never less than 1 so a 1-bit select always exists.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/mux_nx1_rr_if.sv
// Channel-side and output-side handshake bundle for mux_nx1_rr.
interface mux_nx1_rr_if
   import mux_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 8
) ();

   localparam int SW = clog2(N);

   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic [SW-1:0]  sel;
   logic [W-1:0]   out_data;
   logic           out_valid;
   logic           out_ready;
   logic [SW-1:0]  out_chan;

   // Producer/consumer side (testbench or surrounding logic).
   modport master (
      output in_data, in_valid, sel, out_ready,
      input  in_ready, out_data, out_valid, out_chan
   );

   // The mux itself.
   modport slave (
      input  in_data, in_valid, sel, out_ready,
      output in_ready, out_data, out_valid, out_chan
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping N-1 -> 0.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   // Scan N positions starting at ptr; the first hit wins.
   always_comb begin
      int c;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      c   = 0;
      for (int k = 0; k < N; k++) begin
         c = (int'(ptr) + k) % N;
         if (!any && req[c]) begin
            any    = 1'b1;
            gnt[c] = 1'b1;
            idx    = IW'(c);
         end
      end
   end

endmodule

// File: rtl/mux_nx1_rr.sv
// N:1 mux into a single registered output slot, fixed-select or round-robin arbitrated.
module mux_nx1_rr
   import mux_pkg::*;
#(
   parameter int N    = 4,
   parameter int W    = 8,
   parameter int MODE = MODE_RR
) (
   input  logic         clk,
   input  logic         rst,
   mux_nx1_rr_if.slave  bus
);

   localparam int SW = clog2(N);

   logic [W-1:0]  data_q, data_d;
   logic [SW-1:0] chan_q, chan_d;
   logic [SW-1:0] ptr_q, ptr_d;
   logic          valid_q, valid_d;

   logic          load_en;
   logic [N-1:0]  gnt;
   logic [SW-1:0] gnt_idx;
   logic          gnt_any;
   logic          xfer;

   // Slot accepts when empty or draining this cycle; reset blocks every load.
   assign load_en = !rst && (!valid_q || bus.out_ready);

   if (MODE == MODE_RR) begin : g_rr
      rr_arbiter #(
         .N  (N),
         .IW (SW)
      ) u_arb (
         .req (bus.in_valid),
         .ptr (ptr_q),
         .gnt (gnt),
         .idx (gnt_idx),
         .any (gnt_any)
      );
   end else begin : g_fixed
      // Fixed select: out-of-range sel grants nothing.
      always_comb begin
         gnt     = '0;
         gnt_idx = bus.sel;
         gnt_any = 1'b0;
         if (int'(bus.sel) < N) begin
            gnt[bus.sel] = 1'b1;
            gnt_any      = bus.in_valid[bus.sel];
         end
      end
   end

   // Ready only toward the granted channel, and only when the slot can take a word.
   // In fixed mode ready follows sel regardless of that channel's valid.
   assign bus.in_ready = load_en ? gnt : '0;
   assign xfer         = load_en && gnt_any;

   // Slot and pointer next state.
   always_comb begin
      data_d  = data_q;
      chan_d  = chan_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      if (load_en) begin
         valid_d = xfer;
         if (xfer) begin
            data_d = bus.in_data[int'(gnt_idx)*W +: W];
            chan_d = gnt_idx;
            if (MODE == MODE_RR) begin
               ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + SW'(1);
            end
         end
      end
   end

   // State register; reset overrides any same-cycle load or drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         chan_q  <= '0;
         valid_q <= 1'b0;
         ptr_q   <= '0;
      end else begin
         data_q  <= data_d;
         chan_q  <= chan_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.out_data  = data_q;
   assign bus.out_chan  = chan_q;
   assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Bench: fixed-mode and round-robin instances driven in lockstep against a slot/pointer model.
module tb_mux_nx1_rr;
   import mux_pkg::*;

   localparam int N = 4;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [1:0]     sel;
   logic           out_ready;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state, index 0 = fixed-mode DUT, index 1 = round-robin DUT.
   bit         m_valid [2];
   logic [7:0] m_data  [2];
   int         m_chan  [2];
   int         m_ptr   [2];

   always #5 clk = ~clk;

   mux_nx1_rr_if #(.N(N), .W(W)) if_fx ();
   mux_nx1_rr_if #(.N(N), .W(W)) if_rr ();

   assign if_fx.in_data   = in_data;
   assign if_fx.in_valid  = in_valid;
   assign if_fx.sel       = sel;
   assign if_fx.out_ready = out_ready;
   assign if_rr.in_data   = in_data;
   assign if_rr.in_valid  = in_valid;
   assign if_rr.sel       = sel;
   assign if_rr.out_ready = out_ready;

   mux_nx1_rr #(.N(N), .W(W), .MODE(MODE_FIXED)) dut_fx (
      .clk (clk),
      .rst (rst),
      .bus (if_fx.slave)
   );

   mux_nx1_rr #(.N(N), .W(W), .MODE(MODE_RR)) dut_rr (
      .clk (clk),
      .rst (rst),
      .bus (if_rr.slave)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Channel that would be granted if the slot could accept, or -1.
   function automatic int pick(input int m, input logic [N-1:0] v, input int p, input int s);
      if (m == 0) return (s < N) ? s : -1;
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   // One clock: check ready mid-cycle, advance model, check slot after the edge.
   task automatic cycle(input string tag);
      logic [N-1:0] exp_rdy;
      logic [N-1:0] dut_rdy;
      int g;
      bit can_load;
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         g        = pick(m, in_valid, m_ptr[m], int'(sel));
         can_load = !rst && (!m_valid[m] || out_ready);
         exp_rdy  = (can_load && g >= 0) ? N'(1 << g) : '0;
         dut_rdy  = (m == 0) ? if_fx.in_ready : if_rr.in_ready;
         check($sformatf("%s/rdy%0d", tag, m), 64'(dut_rdy), 64'(exp_rdy));
         if (rst) begin
            m_valid[m] = 0; m_data[m] = '0; m_chan[m] = 0; m_ptr[m] = 0;
         end else if (can_load) begin
            if (g >= 0 && in_valid[g]) begin
               m_valid[m] = 1;
               m_data[m]  = in_data[g*W +: W];
               m_chan[m]  = g;
               if (m == 1) m_ptr[m] = (g + 1) % N;
            end else begin
               m_valid[m] = 0;
            end
         end
      end
      @(posedge clk);
      #1;
      check({tag, "/fx_v"}, 64'(if_fx.out_valid), 64'(m_valid[0]));
      check({tag, "/fx_d"}, 64'(if_fx.out_data),  64'(m_data[0]));
      check({tag, "/fx_c"}, 64'(if_fx.out_chan),  64'(m_chan[0]));
      check({tag, "/rr_v"}, 64'(if_rr.out_valid), 64'(m_valid[1]));
      check({tag, "/rr_d"}, 64'(if_rr.out_data),  64'(m_data[1]));
      check({tag, "/rr_c"}, 64'(if_rr.out_chan),  64'(m_chan[1]));
   endtask

   initial begin
      for (int m = 0; m < 2; m++) begin
         m_valid[m] = 0; m_data[m] = '0; m_chan[m] = 0; m_ptr[m] = 0;
      end
      rst = 1'b1; in_valid = '1; in_data = 32'h44332211; sel = 2'd0; out_ready = 1'b1;
      @(posedge clk); #1;

      // Reset with every channel valid: ready stays 0, slot empty.
      cycle("reset");
      check("reset/rr_empty", 64'(if_rr.out_valid), 64'd0);
      check("reset/rr_data0", 64'(if_rr.out_data), 64'd0);
      rst = 1'b0;

      // Fixed select of channel 2.
      sel = 2'd2; in_valid = 4'b0100; in_data = 32'h00A50000;
      cycle("fixed");
      check("fixed/data", 64'(if_fx.out_data), 64'hA5);
      check("fixed/chan", 64'(if_fx.out_chan), 64'd2);

      // Round-robin fairness with all valid and no backpressure (ptr is 3 here).
      in_valid = 4'b1111; in_data = 32'h44332211;
      for (int i = 0; i < 6; i++) cycle($sformatf("fair%0d", i));

      // Backpressure with a 3C word held.
      in_data = 32'h3C3C3C3C;
      cycle("bp_load");
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle($sformatf("bp%0d", i));
         check($sformatf("bp%0d/hold", i), 64'(if_rr.out_data), 64'h3C);
      end
      out_ready = 1'b1; in_data = 32'h11223344;
      cycle("bp_release");

      // Wrap/skip: reset, take ch2 to put ptr at 3, then 0010 -> ch1, 1001 -> ch3.
      rst = 1'b1; cycle("wrap_rst"); rst = 1'b0;
      in_valid = 4'b0100; cycle("wrap_p3");
      in_valid = 4'b0010; cycle("wrap_ch1");
      check("wrap/ch1", 64'(if_rr.out_chan), 64'd1);
      in_valid = 4'b1001; cycle("wrap_ch3");
      check("wrap/ch3", 64'(if_rr.out_chan), 64'd3);
      in_valid = 4'b0000; cycle("wrap_drain");

      // Reset while full and stalled; next grant with all valid goes to ch0.
      in_valid = 4'b1111; cycle("mid_fill");
      in_valid = 4'b0010; cycle("mid_fill2");
      out_ready = 1'b0; rst = 1'b1; cycle("mid_rst");
      rst = 1'b0; out_ready = 1'b1; in_valid = 4'b1111;
      cycle("mid_after");
      check("mid/ch0", 64'(if_rr.out_chan), 64'd0);

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         in_valid  = N'($urandom);
         in_data   = $urandom;
         sel       = 2'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 40) == 0);
         cycle($sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
